// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, instruction field positions and control bundle.
// Used by the fetch, decode and execute stages.
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_N  = 32;
  localparam int REG_AW = 5;
  localparam int IR_W   = 32;

  localparam logic [31:0] NOP_IR = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQZ  = 6'b000100;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 16;

  localparam int CTRL_W = 4;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = 4'b0000;

  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = CTRL_NONE;
    case (op)
      OP_RTYPE: c.reg_write = 1'b1;
      OP_ADDI:  c.reg_write = 1'b1;
      OP_LW:    begin
        c.reg_write = 1'b1;
        c.mem_read  = 1'b1;
      end
      OP_SW:    c.mem_write = 1'b1;
      OP_BEQZ:  c.branch    = 1'b1;
      default:  c = CTRL_NONE;
    endcase
    return c;
  endfunction

  // rt is read as a hazard-relevant source only by R-type and stores.
  function automatic logic rt_is_hazard_src(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW);
  endfunction

  function automatic logic b_uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQZ);
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// IF/ID, MEM/WB and ID/EX signal bundle seen by the decode stage.
// slave = decode stage side, master = surrounding pipeline side.
interface decode_stage_if #(
  parameter int DATA_W = pipe_pkg::DATA_W
);

  logic [31:0]       IF_ID_IR;
  logic [DATA_W-1:0] IF_ID_NPC;
  logic              EX_MEM_Cond;
  logic              MEM_WB_RegWrite;
  logic [4:0]        MEM_WB_Rd;
  logic [DATA_W-1:0] MEM_WB_Data;

  logic              ID_stall;
  logic [31:0]       ID_EX_IR;
  logic [DATA_W-1:0] ID_EX_NPC;
  logic [DATA_W-1:0] ID_EX_A;
  logic [DATA_W-1:0] ID_EX_B;
  logic [DATA_W-1:0] ID_EX_Imm;
  logic [4:0]        ID_EX_Rd;
  logic              ID_EX_RegWrite;
  logic              ID_EX_MemRead;
  logic              ID_EX_MemWrite;
  logic              ID_EX_Branch;

  modport slave (
    input  IF_ID_IR, IF_ID_NPC, EX_MEM_Cond,
    input  MEM_WB_RegWrite, MEM_WB_Rd, MEM_WB_Data,
    output ID_stall,
    output ID_EX_IR, ID_EX_NPC, ID_EX_A, ID_EX_B, ID_EX_Imm, ID_EX_Rd,
    output ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_Branch
  );

  modport master (
    output IF_ID_IR, IF_ID_NPC, EX_MEM_Cond,
    output MEM_WB_RegWrite, MEM_WB_Rd, MEM_WB_Data,
    input  ID_stall,
    input  ID_EX_IR, ID_EX_NPC, ID_EX_A, ID_EX_B, ID_EX_Imm, ID_EX_Rd,
    input  ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_Branch
  );

endinterface

// File: rtl/decode_stage_reg_file.sv
// Architectural register file: two async read ports with write-through bypass,
// one synchronous write port, synchronous active-low clear, r0 hardwired to zero.
module reg_file
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int REG_N  = pipe_pkg::REG_N,
  parameter int AW     = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [AW-1:0]     i_wa,
  input  logic [DATA_W-1:0] i_wd,
  input  logic [AW-1:0]     i_ra1,
  input  logic [AW-1:0]     i_ra2,
  output logic [DATA_W-1:0] o_rd1,
  output logic [DATA_W-1:0] o_rd2
);

  logic [DATA_W-1:0] r_regs [REG_N];
  logic              w_wr_en;

  assign w_wr_en = i_we && (i_wa != {AW{1'b0}});

  // Storage: cleared on reset, written from WB otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < REG_N; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
    end else if (w_wr_en) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  // Read port 1; the bypass lets ID see a value WB writes at the same edge.
  always_comb begin
    if (i_ra1 == {AW{1'b0}}) begin
      o_rd1 = {DATA_W{1'b0}};
    end else if (w_wr_en && (i_wa == i_ra1)) begin
      o_rd1 = i_wd;
    end else begin
      o_rd1 = r_regs[i_ra1];
    end
  end

  // Read port 2, same structure as port 1.
  always_comb begin
    if (i_ra2 == {AW{1'b0}}) begin
      o_rd2 = {DATA_W{1'b0}};
    end else if (w_wr_en && (i_wa == i_ra2)) begin
      o_rd2 = i_wd;
    end else begin
      o_rd2 = r_regs[i_ra2];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// ID stage: decodes IF/ID, reads operands, detects load-use hazards and
// writes the ID/EX latch, inserting a bubble on stall or taken-branch flush.
module decode_stage
  import pipe_pkg::*;
#(
  parameter int          DATA_W = pipe_pkg::DATA_W,
  parameter int          REG_N  = pipe_pkg::REG_N,
  parameter logic [31:0] NOP_IR = pipe_pkg::NOP_IR
) (
  input logic           clk,
  input logic           reset,
  decode_stage_if.slave bus
);

  logic [31:0]       w_ir;
  logic [5:0]        w_op;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [4:0]        w_rd;
  logic [15:0]       w_imm;
  logic              w_is_nop;
  ctrl_t             w_ctrl;
  logic [4:0]        w_dest;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic [DATA_W-1:0] w_b_val;
  logic [DATA_W-1:0] w_imm_ext;
  logic              w_hazard;
  logic              w_bubble;

  logic [31:0]       r_ir;
  logic [DATA_W-1:0] r_npc;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_imm;
  logic [4:0]        r_rd;
  ctrl_t             r_ctrl;

  assign w_ir     = bus.IF_ID_IR;
  assign w_op     = w_ir[OP_MSB:OP_LSB];
  assign w_rs     = w_ir[RS_MSB:RS_LSB];
  assign w_rt     = w_ir[RT_MSB:RT_LSB];
  assign w_rd     = w_ir[RD_MSB:RD_LSB];
  assign w_imm    = w_ir[IMM_MSB:IMM_LSB];
  assign w_is_nop = (w_ir == NOP_IR);

  reg_file #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N)
  ) u_reg_file (
    .clk   (clk),
    .reset (reset),
    .i_we  (bus.MEM_WB_RegWrite),
    .i_wa  (bus.MEM_WB_Rd),
    .i_wd  (bus.MEM_WB_Data),
    .i_ra1 (w_rs),
    .i_ra2 (w_rt),
    .o_rd1 (w_rs_val),
    .o_rd2 (w_rt_val)
  );

  // Control and destination decode; the NOP encoding is a bubble, not an R-type.
  always_comb begin
    w_ctrl = CTRL_NONE;
    w_dest = 5'd0;
    if (w_is_nop) begin
      w_ctrl = CTRL_NONE;
      w_dest = 5'd0;
    end else begin
      w_ctrl = decode_ctrl(w_op);
      case (w_op)
        OP_RTYPE: w_dest = w_rd;
        OP_ADDI:  w_dest = w_rt;
        OP_LW:    w_dest = w_rt;
        default:  w_dest = 5'd0;
      endcase
    end
  end

  // Operand B and immediate extension.
  always_comb begin
    w_b_val   = {DATA_W{1'b0}};
    w_imm_ext = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
    if (b_uses_rt(w_op)) begin
      w_b_val = w_rt_val;
    end else begin
      w_b_val = {DATA_W{1'b0}};
    end
  end

  // Load-use hazard against the load currently sitting in ID/EX.
  assign w_hazard = r_ctrl.mem_read && (r_rd != 5'd0) &&
                    ((r_rd == w_rs) || (rt_is_hazard_src(w_op) && (r_rd == w_rt)));

  // A taken branch flushes regardless; it also cancels the stall so fetch can redirect.
  assign w_bubble     = bus.EX_MEM_Cond || w_hazard;
  assign bus.ID_stall = w_hazard && !bus.EX_MEM_Cond;

  // ID/EX pipeline register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ir   <= NOP_IR;
      r_npc  <= {DATA_W{1'b0}};
      r_a    <= {DATA_W{1'b0}};
      r_b    <= {DATA_W{1'b0}};
      r_imm  <= {DATA_W{1'b0}};
      r_rd   <= 5'd0;
      r_ctrl <= CTRL_NONE;
    end else if (w_bubble) begin
      r_ir   <= NOP_IR;
      r_npc  <= {DATA_W{1'b0}};
      r_a    <= {DATA_W{1'b0}};
      r_b    <= {DATA_W{1'b0}};
      r_imm  <= {DATA_W{1'b0}};
      r_rd   <= 5'd0;
      r_ctrl <= CTRL_NONE;
    end else begin
      r_ir   <= w_ir;
      r_npc  <= bus.IF_ID_NPC;
      r_a    <= w_rs_val;
      r_b    <= w_b_val;
      r_imm  <= w_imm_ext;
      r_rd   <= w_dest;
      r_ctrl <= w_ctrl;
    end
  end

  assign bus.ID_EX_IR       = r_ir;
  assign bus.ID_EX_NPC      = r_npc;
  assign bus.ID_EX_A        = r_a;
  assign bus.ID_EX_B        = r_b;
  assign bus.ID_EX_Imm      = r_imm;
  assign bus.ID_EX_Rd       = r_rd;
  assign bus.ID_EX_RegWrite = r_ctrl.reg_write;
  assign bus.ID_EX_MemRead  = r_ctrl.mem_read;
  assign bus.ID_EX_MemWrite = r_ctrl.mem_write;
  assign bus.ID_EX_Branch   = r_ctrl.branch;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, decode, bypass, load-use stall,
// flush priority, r0 write suppression and reset during a stall.
module tb_decode_stage;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  decode_stage_if bus ();

  decode_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [3:0] ctrl;
  assign ctrl = {bus.ID_EX_RegWrite, bus.ID_EX_MemRead, bus.ID_EX_MemWrite, bus.ID_EX_Branch};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic set_in(input logic [31:0] ir, input logic [31:0] npc, input logic cond,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
    bus.IF_ID_IR        = ir;
    bus.IF_ID_NPC       = npc;
    bus.EX_MEM_Cond     = cond;
    bus.MEM_WB_RegWrite = we;
    bus.MEM_WB_Rd       = wa;
    bus.MEM_WB_Data     = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_ir"},   bus.ID_EX_IR, 32'h0000_0000);
    check({tag, "_ctrl"}, {28'd0, ctrl}, 32'h0000_0000);
    check({tag, "_rd"},   {27'd0, bus.ID_EX_Rd}, 32'h0000_0000);
  endtask

  initial begin
    // 1. reset held for two cycles
    set_in(enc_r(5'd5, 5'd0, 5'd3), 32'h0000_0040, 1'b0, 1'b1, 5'd7, 32'h5555_5555);
    tick();
    tick();
    check_bubble("rst");
    check("rst_npc",   bus.ID_EX_NPC, 32'h0000_0000);
    check("rst_a",     bus.ID_EX_A,   32'h0000_0000);
    check("rst_b",     bus.ID_EX_B,   32'h0000_0000);
    check("rst_imm",   bus.ID_EX_Imm, 32'h0000_0000);
    check("rst_stall", {31'd0, bus.ID_stall}, 32'h0000_0000);
    reset = 1'b1;
    set_in(enc_r(5'd1, 5'd7, 5'd9), 32'h0000_0004, 1'b0, 1'b0, 5'd0, 32'h0000_0000);
    tick();
    check("rf0_a", bus.ID_EX_A, 32'h0000_0000);
    check("rf0_b", bus.ID_EX_B, 32'h0000_0000);
    set_in(enc_r(5'd17, 5'd31, 5'd9), 32'h0000_0008, 1'b0, 1'b0, 5'd0, 32'h0000_0000);
    tick();
    check("rf1_a", bus.ID_EX_A, 32'h0000_0000);
    check("rf1_b", bus.ID_EX_B, 32'h0000_0000);

    // 2. WB r5 with same-cycle read of r5
    set_in(enc_r(5'd5, 5'd0, 5'd3), 32'h0000_0104, 1'b0, 1'b1, 5'd5, 32'h0000_1234);
    tick();
    check("byp_a",    bus.ID_EX_A,   32'h0000_1234);
    check("byp_b",    bus.ID_EX_B,   32'h0000_0000);
    check("byp_rd",   {27'd0, bus.ID_EX_Rd}, 32'd3);
    check("byp_ctrl", {28'd0, ctrl}, 32'h0000_0008);
    check("byp_ir",   bus.ID_EX_IR,  32'h00A0_1820);
    check("byp_npc",  bus.ID_EX_NPC, 32'h0000_0104);
    check("byp_imm",  bus.ID_EX_Imm, 32'h0000_1820);
    set_in(enc_r(5'd0, 5'd5, 5'd6), 32'h0000_0108, 1'b0, 1'b1, 5'd1, 32'h0000_0100);
    tick();
    check("keep_a",  bus.ID_EX_A, 32'h0000_0000);
    check("keep_b",  bus.ID_EX_B, 32'h0000_1234);
    check("keep_rd", {27'd0, bus.ID_EX_Rd}, 32'd6);

    // 3. LW r2,4(r1) then ADD r4,r2,r2
    set_in(enc_i(6'h23, 5'd1, 5'd2, 16'h0004), 32'h0000_010C, 1'b0, 1'b0, 5'd0, 32'h0000_0000);
    #1 check("lw_nostall", {31'd0, bus.ID_stall}, 32'd0);
    @(negedge clk);
    tick();
    check("lw_ctrl", {28'd0, ctrl}, 32'h0000_000C);
    check("lw_rd",   {27'd0, bus.ID_EX_Rd}, 32'd2);
    check("lw_a",    bus.ID_EX_A,   32'h0000_0100);
    check("lw_b",    bus.ID_EX_B,   32'h0000_0000);
    check("lw_imm",  bus.ID_EX_Imm, 32'h0000_0004);
    set_in(enc_r(5'd2, 5'd2, 5'd4), 32'h0000_0110, 1'b0, 1'b1, 5'd2, 32'h0000_ABCD);
    #1 check("lu_stall", {31'd0, bus.ID_stall}, 32'd1);
    tick();
    check_bubble("lu_bub");
    check("lu_bub_a", bus.ID_EX_A, 32'h0000_0000);
    set_in(enc_r(5'd2, 5'd2, 5'd4), 32'h0000_0110, 1'b0, 1'b0, 5'd0, 32'h0000_0000);
    #1 check("lu_release", {31'd0, bus.ID_stall}, 32'd0);
    tick();
    check("lu_rd",   {27'd0, bus.ID_EX_Rd}, 32'd4);
    check("lu_ctrl", {28'd0, ctrl}, 32'h0000_0008);
    check("lu_a",    bus.ID_EX_A, 32'h0000_ABCD);
    check("lu_b",    bus.ID_EX_B, 32'h0000_ABCD);

    // ADDI whose rt matches the load destination is not a source: no stall
    set_in(enc_i(6'h23, 5'd1, 5'd2, 16'h0004), 32'h0000_0114, 1'b0, 1'b0, 5'd0, 32'h0000_0000);
    tick();
    set_in(enc_i(6'h08, 5'd3, 5'd2, 16'h0001), 32'h0000_0118, 1'b0, 1'b0, 5'd0, 32'h0000_0000);
    #1 check("addi_rt_nostall", {31'd0, bus.ID_stall}, 32'd0);
    tick();
    check("addi_rt_rd", {27'd0, bus.ID_EX_Rd}, 32'd2);

    // 4. ADDI r7,r0,-1 and other opcodes
    set_in(enc_i(6'h08, 5'd0, 5'd7, 16'hFFFF), 32'h0000_011C, 1'b0, 1'b0, 5'd0, 32'h0000_0000);
    tick();
    check("addi_imm",  bus.ID_EX_Imm, 32'hFFFF_FFFF);
    check("addi_rd",   {27'd0, bus.ID_EX_Rd}, 32'd7);
    check("addi_b",    bus.ID_EX_B, 32'h0000_0000);
    check("addi_ctrl", {28'd0, ctrl}, 32'h0000_0008);
    set_in(enc_i(6'h2B, 5'd1, 5'd5, 16'h0008), 32'h0000_0120, 1'b0, 1'b0, 5'd0, 32'h0000_0000);
    tick();
    check("sw_ctrl", {28'd0, ctrl}, 32'h0000_0002);
    check("sw_rd",   {27'd0, bus.ID_EX_Rd}, 32'd0);
    check("sw_a",    bus.ID_EX_A, 32'h0000_0100);
    check("sw_b",    bus.ID_EX_B, 32'h0000_1234);
    set_in(enc_i(6'h04, 5'd1, 5'd5, 16'h8000), 32'h0000_0124, 1'b0, 1'b0, 5'd0, 32'h0000_0000);
    tick();
    check("beqz_ctrl", {28'd0, ctrl}, 32'h0000_0001);
    check("beqz_imm",  bus.ID_EX_Imm, 32'hFFFF_8000);
    check("beqz_b",    bus.ID_EX_B, 32'h0000_1234);
    check("beqz_rd",   {27'd0, bus.ID_EX_Rd}, 32'd0);
    set_in(enc_i(6'h3F, 5'd1, 5'd7, 16'h0010), 32'h0000_0128, 1'b0, 1'b0, 5'd0, 32'h0000_0000);
    tick();
    check("unk_ctrl", {28'd0, ctrl}, 32'h0000_0000);
    check("unk_rd",   {27'd0, bus.ID_EX_Rd}, 32'd0);
    check("unk_b",    bus.ID_EX_B, 32'h0000_0000);
    check("unk_a",    bus.ID_EX_A, 32'h0000_0100);

    // 5. flush with ADD in IF/ID, then flush over a pending load-use pair
    set_in(enc_r(5'd5, 5'd0, 5'd3), 32'h0000_012C, 1'b1, 1'b0, 5'd0, 32'h0000_0000);
    tick();
    check_bubble("fl");
    check("fl_npc", bus.ID_EX_NPC, 32'h0000_0000);
    set_in(enc_i(6'h23, 5'd1, 5'd2, 16'h0004), 32'h0000_0200, 1'b0, 1'b0, 5'd0, 32'h0000_0000);
    tick();
    set_in(enc_r(5'd2, 5'd2, 5'd4), 32'h0000_0204, 1'b1, 1'b0, 5'd0, 32'h0000_0000);
    #1 check("fl_lu_stall", {31'd0, bus.ID_stall}, 32'd0);
    tick();
    check_bubble("fl_lu");
    set_in(enc_r(5'd2, 5'd2, 5'd4), 32'h0000_0300, 1'b0, 1'b0, 5'd0, 32'h0000_0000);
    #1 check("fl_after_stall", {31'd0, bus.ID_stall}, 32'd0);
    tick();
    check("fl_after_rd", {27'd0, bus.ID_EX_Rd}, 32'd4);

    // 6. write to r0 is dropped, including the same-cycle bypass
    set_in(enc_r(5'd0, 5'd0, 5'd1), 32'h0000_0304, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    tick();
    check("r0_byp_a", bus.ID_EX_A, 32'h0000_0000);
    check("r0_byp_b", bus.ID_EX_B, 32'h0000_0000);
    set_in(enc_r(5'd0, 5'd0, 5'd1), 32'h0000_0308, 1'b0, 1'b0, 5'd0, 32'h0000_0000);
    tick();
    check("r0_a", bus.ID_EX_A, 32'h0000_0000);
    check("r0_b", bus.ID_EX_B, 32'h0000_0000);

    // reset asserted while a load-use stall is active
    set_in(enc_i(6'h23, 5'd1, 5'd2, 16'h0004), 32'h0000_0400, 1'b0, 1'b0, 5'd0, 32'h0000_0000);
    tick();
    set_in(enc_r(5'd2, 5'd2, 5'd4), 32'h0000_0404, 1'b0, 1'b0, 5'd0, 32'h0000_0000);
    #1 check("rs_stall", {31'd0, bus.ID_stall}, 32'd1);
    reset = 1'b0;
    tick();
    check_bubble("rs");
    reset = 1'b1;
    #1 check("rs_stall_clr", {31'd0, bus.ID_stall}, 32'd0);
    tick();
    check("rs_issue_rd", {27'd0, bus.ID_EX_Rd}, 32'd4);
    check("rs_issue_a",  bus.ID_EX_A, 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
